// File: rtl/jk_cmd_seq.sv
// Command sequencer driving the j/k inputs of a JK flop from a small command FIFO.
// Define JK_CMD_SHADOW_EN to add the q_fb/mismatch shadow-model checker.
module jk_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int REP_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [REP_W-1:0]         cmd_rep,
   output logic                     j,
   output logic                     k,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
`ifdef JK_CMD_SHADOW_EN
   ,
   input  logic                     q_fb,
   output logic                     mismatch
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = REP_W + 2;
   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   logic [EW-1:0]    r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   state_t           r_state;
   logic [1:0]       r_cur_op;
   logic [REP_W-1:0] r_remaining;
   logic [1:0]       r_jk;

   logic             w_ready;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [1:0]       w_head_op;
   logic [REP_W-1:0] w_head_rep;

   assign w_ready    = (r_count < LP_DEPTH);
   assign w_empty    = (r_count == '0);
   assign w_push     = cmd_valid && w_ready;
   // In IDLE any queued entry is taken; in ISSUE only once the current op has run out.
   assign w_pop      = !w_empty && ((r_state == S_IDLE) || (r_remaining == '0));
   assign w_head_op  = r_mem[r_rptr][EW-1 -: 2];
   assign w_head_rep = r_mem[r_rptr][REP_W-1:0];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= {cmd_op, cmd_rep};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_jk    <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_state <= S_ISSUE;
                  r_jk    <= w_head_op;
               end else begin
                  r_jk    <= 2'b00;
               end
            end
            default: begin
               if (r_remaining != '0) begin
                  r_jk    <= r_cur_op;
               end else if (w_pop) begin
                  r_jk    <= w_head_op;
               end else begin
                  r_state <= S_IDLE;
                  r_jk    <= 2'b00;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_pop) begin
         r_cur_op    <= w_head_op;
         r_remaining <= w_head_rep;
      end else if ((r_state == S_ISSUE) && (r_remaining != '0)) begin
         r_remaining <= r_remaining - REP_W'(1);
      end
   end

   assign cmd_ready = w_ready;
   assign busy      = (r_state == S_ISSUE) || !w_empty;
   assign count     = r_count;
   assign j         = r_jk[1];
   assign k         = r_jk[0];

`ifdef JK_CMD_SHADOW_EN
   logic r_q_exp;
   logic r_q_known;
   logic r_mismatch;

   // The flop itself has no reset, so its expected value is meaningless until a set/reset op lands.
   always_ff @(posedge clk) begin
      case (r_jk)
         2'b01:   r_q_exp <= 1'b0;
         2'b10:   r_q_exp <= 1'b1;
         2'b11:   r_q_exp <= ~r_q_exp;
         default: r_q_exp <= r_q_exp;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q_known  <= 1'b0;
         r_mismatch <= 1'b0;
      end else begin
         if ((r_jk == 2'b01) || (r_jk == 2'b10)) r_q_known <= 1'b1;
         if (r_q_known && (q_fb != r_q_exp))     r_mismatch <= 1'b1;
      end
   end

   assign mismatch = r_mismatch;
`endif

endmodule
